// File: rtl/spi_slv_pkg.sv
// Shared defaults and helpers for the SPI slave register-bank model.
package spi_slv_pkg;

   localparam int FRAME_W_DEF  = 60;
   localparam int ADDR_W_DEF   = 10;
   localparam int ADDR_MSB_DEF = 57;
   localparam int DEPTH_DEF    = 32;
   localparam int OUT_W_DEF    = 64;

   localparam logic [9:0] RD_REQ_ADDR_DEF  = 10'h009;
   localparam logic [9:0] RD_EXIT_ADDR_DEF = 10'h001;

   // Widest frame the address helper accepts.
   localparam int MAX_W = 256;

   // Pull the address field frame[msb -: w] out as a zero-extended 32-bit value.
   function automatic logic [31:0] addr_of(input logic [MAX_W-1:0] frame,
                                           input int msb, input int w);
      logic [31:0] a;
      a = 32'(frame >> (msb - w + 1));
      if (w < 32) a = a & ((32'd1 << w) - 32'd1);
      return a;
   endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Two-flop synchroniser with a third stage for rise/fall detection.
module spi_slv_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic mclk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   // Shift the pin through three stages; all start at the idle level.
   always_ff @(posedge mclk) begin
      if (rst) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
         s3 <= RST_VAL;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign dout = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slv_regbank.sv
// SPI mode-0 slave model with a directly addressed register bank.
// Optional read-back path (sticky read mode, tx shifter) is built when
// SPI_SLV_RDBACK_EN is defined; otherwise miso is pure rx loopback.
module spi_slv_regbank
   import spi_slv_pkg::*;
#(
   parameter int FRAME_W  = FRAME_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ADDR_MSB = ADDR_MSB_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter logic [ADDR_W-1:0] RD_REQ_ADDR  = ADDR_W'(RD_REQ_ADDR_DEF),
   parameter logic [ADDR_W-1:0] RD_EXIT_ADDR = ADDR_W'(RD_EXIT_ADDR_DEF)
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             scl,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic [OUT_W-1:0] wdao,
   output logic             wvld,
   output logic             ferr,
   output logic             rd_mode
);

   localparam int CNT_W = $clog2(FRAME_W + 2);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

   logic scl_lvl, scl_rise, scl_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_slv_sync #(.RST_VAL(1'b0)) u_sync_scl (
      .mclk(mclk), .rst(rst), .din(scl),
      .dout(scl_lvl), .rise(scl_rise), .fall(scl_fall));
   spi_slv_sync #(.RST_VAL(1'b1)) u_sync_cs (
      .mclk(mclk), .rst(rst), .din(cs_n),
      .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall));
   spi_slv_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .mclk(mclk), .rst(rst), .din(mosi),
      .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

   logic unused_sync;
   assign unused_sync = ^{scl_lvl, cs_lvl, mosi_rise, mosi_fall};

   logic [1:0]         settle;
   logic               active;
   logic               cs_start;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] rx_sr;
   logic [FRAME_W-1:0] wr_data;
   logic [FRAME_W-1:0] regs [DEPTH];
   logic [31:0]        commit_addr;
   logic               addr_in;

   // The cs_n synchroniser resets high, so a pin held low across reset
   // release shows a fall ~2 cycles later; ignoring falls until the
   // pipeline has flushed keeps that from opening a frame.
   assign cs_start = cs_fall & (settle == 2'd3);

   // Frame reception: bit counting, rx shifting, commit or discard on cs_n rise.
   always_ff @(posedge mclk) begin
      if (rst) begin
         settle  <= 2'd0;
         active  <= 1'b0;
         bit_cnt <= '0;
         rx_sr   <= '0;
         wr_data <= '0;
         wvld    <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         wvld <= 1'b0;
         ferr <= 1'b0;
         if (settle != 2'd3) settle <= settle + 2'd1;
         if (cs_start) begin
            active  <= 1'b1;
            rx_sr   <= '0;
            bit_cnt <= '0;
         end else if (cs_rise) begin
            // scl edges coinciding with cs_n rise are dropped here
            active <= 1'b0;
            if (active) begin
               if (bit_cnt == CNT_FULL) begin
                  wr_data <= rx_sr;
                  wvld    <= 1'b1;
               end else begin
                  ferr <= 1'b1;
               end
            end
         end else if (active && scl_rise) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], mosi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   assign wdao        = OUT_W'(wr_data);
   assign commit_addr = addr_of(MAX_W'(wr_data), ADDR_MSB, ADDR_W);
   assign addr_in     = commit_addr < 32'(DEPTH);

   // Register bank: written in the commit cycle, out-of-range addresses dropped.
   always_ff @(posedge mclk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wvld && addr_in) begin
         regs[commit_addr[IDX_W-1:0]] <= wr_data;
      end
   end

`ifdef SPI_SLV_RDBACK_EN
   logic [FRAME_W-1:0] rd_data;
   logic [FRAME_W-1:0] tx_sr;
   logic [31:0]        tgt;
   logic               tgt_in;

   assign tgt    = 32'(wr_data[ADDR_W-1:0]);
   assign tgt_in = tgt < 32'(DEPTH);

   // Read mode control: request captures the target (bypassing the bank when
   // the target is the register being written this cycle), exit clears mode.
   always_ff @(posedge mclk) begin
      if (rst) begin
         rd_data <= '0;
         rd_mode <= 1'b0;
      end else if (wvld) begin
         if (commit_addr == 32'(RD_REQ_ADDR)) begin
            rd_mode <= 1'b1;
            if (!tgt_in)                  rd_data <= '0;
            else if (tgt == commit_addr)  rd_data <= wr_data;
            else                          rd_data <= regs[tgt[IDX_W-1:0]];
         end else if (commit_addr == 32'(RD_EXIT_ADDR)) begin
            rd_mode <= 1'b0;
         end
      end
   end

   // Tx shifter: reloaded at each frame start, shifted out MSB first on scl fall.
   always_ff @(posedge mclk) begin
      if (rst) begin
         tx_sr <= '0;
      end else if (cs_start) begin
         if (rd_mode) tx_sr <= rd_data;
      end else if (active && scl_fall && !cs_rise && rd_mode) begin
         tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end
   end

   assign miso = rd_mode ? tx_sr[FRAME_W-1] : rx_sr[FRAME_W-1];
`else
   logic unused_cfg;
   assign unused_cfg = ^{RD_REQ_ADDR, RD_EXIT_ADDR};
   assign rd_mode    = 1'b0;
   assign miso       = rx_sr[FRAME_W-1];
`endif

endmodule

// File: tb/tb_spi_slv_regbank.sv
// Randomised scoreboard bench for spi_slv_regbank.
module tb_spi_slv_regbank;

   localparam int FW    = 60;
   localparam int AW    = 10;
   localparam int AMSB  = 57;
   localparam int DEPTH = 32;
   localparam int OUT_W = 64;
`ifdef SPI_SLV_RDBACK_EN
   localparam bit RDBK = 1'b1;
`else
   localparam bit RDBK = 1'b0;
`endif

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   logic scl  = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic             miso;
   logic [OUT_W-1:0] wdao;
   logic             wvld;
   logic             ferr;
   logic             rd_mode;

   always #5 mclk = ~mclk;

   spi_slv_regbank #(
      .FRAME_W(FW), .ADDR_W(AW), .ADDR_MSB(AMSB), .DEPTH(DEPTH), .OUT_W(OUT_W),
      .RD_REQ_ADDR(10'h009), .RD_EXIT_ADDR(10'h001)
   ) dut (
      .mclk(mclk), .rst(rst), .scl(scl), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .wdao(wdao), .wvld(wvld), .ferr(ferr), .rd_mode(rd_mode)
   );

   typedef struct {
      bit          is_err;
      logic [63:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // Reference state: what the register file and read mode should hold.
   logic [FW-1:0] m_regs [DEPTH];
   logic [FW-1:0] m_rd_data;
   bit            m_rd_mode;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge mclk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_rd_data = '0;
      m_rd_mode = 1'b0;
   endtask

   // Expected miso once j bits have been clocked in (j == nbits: after the last rise).
   function automatic logic exp_miso(input int j, input int nbits, input logic [63:0] v);
      int falls;
      falls = (j < nbits) ? j : nbits - 1;
      if (m_rd_mode) return (falls < FW) ? m_rd_data[FW-1-falls] : 1'b0;
      return (j >= FW) ? v[nbits-1-(j-FW)] : 1'b0;
   endfunction

   // A complete frame: queue the wvld pulse, update bank and read mode.
   task automatic model_commit(input logic [FW-1:0] f);
      int a, t;
      exp_t e;
      e.is_err = 1'b0;
      e.data   = 64'(f);
      exp_q.push_back(e);
      a = int'(f[AMSB -: AW]);
      if (a < DEPTH) m_regs[a] = f;
      if (RDBK) begin
         if (a == 9) begin
            t = int'(f[AW-1:0]);
            m_rd_data = (t < DEPTH) ? m_regs[t] : '0;
            m_rd_mode = 1'b1;
         end else if (a == 1) begin
            m_rd_mode = 1'b0;
         end
      end
   endtask

   function automatic logic [63:0] mk(input logic [9:0] addr, input logic [11:0] lo);
      logic [63:0] v;
      v = {$urandom, $urandom};
      v[63:FW] = '0;
      v[AMSB -: AW] = addr;
      v[11:0] = lo;
      return v;
   endfunction

   // Drive one frame of nbits (MSB first). rst_at >= 0 pulses reset before that bit.
   task automatic send(input logic [63:0] v, input int nbits, input int rst_at);
      bit   post_rst;
      exp_t e;
      post_rst = 1'b0;
      cs_n = 1'b0;
      cyc(4);
      for (int j = 0; j < nbits; j++) begin
         if (j == rst_at) begin
            rst = 1'b1;
            cyc(3);
            chk("rst_miso", 64'(miso), 64'd0);
            chk("rst_wdao", wdao, 64'd0);
            chk("rst_wvld", 64'(wvld), 64'd0);
            chk("rst_ferr", 64'(ferr), 64'd0);
            chk("rst_rd_mode", 64'(rd_mode), 64'd0);
            model_reset();
            rst = 1'b0;
            post_rst = 1'b1;
         end
         mosi = v[nbits-1-j];
         cyc(4);
         chk("miso_bit", 64'(miso), post_rst ? 64'd0 : 64'(exp_miso(j, nbits, v)));
         scl = 1'b1;
         cyc(4);
         if (j == nbits - 1)
            chk("miso_last", 64'(miso), post_rst ? 64'd0 : 64'(exp_miso(nbits, nbits, v)));
         scl = 1'b0;
      end
      cyc(4);
      cs_n = 1'b1;
      if (rst_at < 0) begin
         if (nbits == FW) model_commit(v[FW-1:0]);
         else begin
            e.is_err = 1'b1;
            e.data   = '0;
            exp_q.push_back(e);
         end
      end
      cyc(10);
      chk("pending_events", 64'(exp_q.size()), 64'd0);
      chk("rd_mode", 64'(rd_mode), 64'(m_rd_mode));
   endtask

   // Monitor: every wvld/ferr pulse must match the head of the expectation queue.
   always @(negedge mclk) begin
      exp_t e;
      if (!rst && (wvld || ferr)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse wvld=%0b ferr=%0b wdao=%h want=no_pulse", wvld, ferr, wdao);
         end else begin
            e = exp_q.pop_front();
            if (wvld == ferr || ferr != e.is_err || (!e.is_err && wdao !== e.data)) begin
               miscompares++;
               $display("FAIL pulse wvld=%0b ferr=%0b wdao=%h want_err=%0b want_wdao=%h",
                        wvld, ferr, wdao, e.is_err, e.data);
            end
         end
      end
   end

   initial begin
      int          kind, len;
      logic [9:0]  a;
      model_reset();
      rst = 1'b1;
      cyc(4);
      chk("reset_miso", 64'(miso), 64'd0);
      chk("reset_wdao", wdao, 64'd0);
      chk("reset_wvld", 64'(wvld), 64'd0);
      chk("reset_ferr", 64'(ferr), 64'd0);
      chk("reset_rd_mode", 64'(rd_mode), 64'd0);
      rst = 1'b0;
      cyc(6);

      // Basic write and loopback
      send(mk(10'h004, 12'h123), FW, -1);
      send(mk(10'h010, 12'h000), FW, -1);
      // Read request of reg 4, three read frames, exit, loopback again
      send(mk(10'h009, 12'h004), FW, -1);
      send(mk(10'h011, 12'h000), FW, -1);
      send(mk(10'h012, 12'h000), FW, -1);
      send(mk(10'h013, 12'h000), FW, -1);
      send(mk(10'h001, 12'h000), FW, -1);
      send(mk(10'h014, 12'h000), FW, -1);
      // Truncated, overlong and empty frames
      send(mk(10'h004, 12'hABC), FW - 1, -1);
      send(mk(10'h004, 12'hABC), FW + 1, -1);
      send(64'd0, 0, -1);
      // Read request targeting itself, then out-of-range target and address
      send(mk(10'h009, 12'h009), FW, -1);
      send(mk(10'h015, 12'h000), FW, -1);
      send(mk(10'h009, 12'h3FF), FW, -1);
      send(mk(10'h016, 12'h000), FW, -1);
      send(mk(10'h200, 12'h004), FW, -1);
      send(mk(10'h009, 12'h004), FW, -1);
      send(mk(10'h017, 12'h000), FW, -1);
      send(mk(10'h001, 12'h000), FW, -1);

      // Randomised mix
      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            len = $urandom_range(0, 3);
            len = (len == 0) ? 0 : (len == 1) ? FW - 1 : (len == 2) ? FW + 1 : $urandom_range(1, FW - 2);
            send(mk(10'($urandom_range(0, 31)), 12'($urandom)), len, -1);
         end else begin
            if (kind == 1)      a = ($urandom_range(0, 1) != 0) ? 10'h009 : 10'h001;
            else if (kind == 2) a = 10'($urandom_range(32, 1023));
            else                a = 10'($urandom_range(0, DEPTH - 1));
            send(mk(a, ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, DEPTH - 1))),
                 FW, -1);
         end
      end

      // Reset in the middle of a frame with cs_n held low, then a clean frame
      send(mk(10'h009, 12'h004), FW, -1);
      send(mk(10'h005, 12'h055), FW, 30);
      send(mk(10'h006, 12'h066), FW, -1);
      send(mk(10'h018, 12'h000), FW, -1);

      cyc(10);
      chk("final_queue", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
